// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) constants, types and the syndrome function.
// Codeword layout is {p1,p2,d0,p3,d1,d2,d3} on bits [6:0]; Hamming position k = bit 7-k.
package hamming_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    localparam int unsigned P1_BIT = 6;
    localparam int unsigned P2_BIT = 5;
    localparam int unsigned D0_BIT = 4;
    localparam int unsigned P3_BIT = 3;
    localparam int unsigned D1_BIT = 2;
    localparam int unsigned D2_BIT = 1;
    localparam int unsigned D3_BIT = 0;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syn_t;

    // Returns {s3,s2,s1}; a nonzero value is the Hamming position of a single-bit error.
    function automatic syn_t hamming_syndrome(input code_t c);
        logic s1, s2, s3;
        s1 = c[P1_BIT] ^ c[D0_BIT] ^ c[D1_BIT] ^ c[D3_BIT];
        s2 = c[P2_BIT] ^ c[D0_BIT] ^ c[D2_BIT] ^ c[D3_BIT];
        s3 = c[P3_BIT] ^ c[D1_BIT] ^ c[D2_BIT] ^ c[D3_BIT];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_decoder_74_syndrome.sv
// hamming_syndrome_74: purely combinational codeword -> syndrome.
module hamming_syndrome_74
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn
);

    assign syn = hamming_syndrome(code);

endmodule

// File: rtl/hamming_decoder_74.sv
// hamming_decoder_74: two-stage Hamming(7,4) single-error-correcting decoder
// with valid/ready handshakes on both sides and a global enable.
// Optional saturating corrected-word counter: define HAMMING_DEC_ERR_CNT_EN.
module hamming_decoder_74
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome_out,
    output logic              corrected,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_count
);

    logic  s1_valid;
    code_t s1_code;
    syn_t  s1_syn;
    syn_t  syn_in;
    logic  s2_load;
    logic  s1_load;
    logic  accept;
    code_t flip_mask;
    code_t fixed_code;
    data_t fixed_data;

    hamming_syndrome_74 u_syndrome (
        .code (code_in),
        .syn  (syn_in)
    );

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = ena && s1_load;
    assign accept   = in_valid && in_ready;

    // Stage 1: capture the accepted codeword and its syndrome; code_in is only sampled on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (ena && s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
                s1_syn  <= syn_in;
            end
        end
    end

    // Correction: one-hot mask selecting codeword bit 7-syn, empty when syn is zero.
    always_comb begin
        flip_mask = '0;
        for (int unsigned k = 1; k <= CODE_W; k++) begin
            if (s1_syn == SYN_W'(k)) flip_mask = CODE_W'(1) << (CODE_W - k);
        end
    end

    assign fixed_code = s1_code ^ flip_mask;
    assign fixed_data = {fixed_code[D3_BIT], fixed_code[D2_BIT], fixed_code[D1_BIT], fixed_code[D0_BIT]};

    // Stage 2: register corrected data; held stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            syndrome_out <= '0;
            corrected    <= 1'b0;
        end else if (ena && s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out     <= fixed_data;
                syndrome_out <= s1_syn;
                corrected    <= (s1_syn != '0);
            end
        end
    end

`ifdef HAMMING_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    // Saturating count of corrected words leaving the block; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (ena) begin
            if (cnt_clr) begin
                err_cnt <= '0;
            end else if (out_valid && out_ready && corrected && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign err_count = err_cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_74.sv
// tb_hamming_decoder_74: directed and randomized checks against a brute-force
// nearest-codeword decoder model and a transaction queue.
// Counter checks follow HAMMING_DEC_ERR_CNT_EN when it is defined for the build.
module tb_hamming_decoder_74;

    localparam int unsigned CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMMING_DEC_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b1;
    logic [6:0]       code_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       data_out;
    logic [2:0]       syndrome_out;
    logic             corrected;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;
    bit   armed = 1'b0;

    hamming_decoder_74 #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .code_in      (code_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .syndrome_out (syndrome_out),
        .corrected    (corrected),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cnt_clr      (cnt_clr),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard Hamming(7,4) encoder, data {d3,d2,d1,d0}.
    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[0]^d[1]^d[3], d[0]^d[2]^d[3], d[0], d[1]^d[2]^d[3], d[1], d[2], d[3]};
    endfunction

    // Nearest-codeword decode: every 7-bit word lies within distance 1 of exactly one codeword.
    function automatic exp_t ref_decode(input logic [6:0] c);
        exp_t r;
        logic [6:0] diff;
        logic [3:0] dv;
        r.data = '0;
        r.syn  = '0;
        r.corr = 1'b0;
        for (int d = 0; d < 16; d++) begin
            dv   = d[3:0];
            diff = encode(dv) ^ c;
            if ($countones(diff) <= 1) begin
                r.data = dv;
                r.corr = (diff != 0);
                for (int b = 0; b < 7; b++) if (diff[b]) r.syn = 3'(7 - b);
            end
        end
        return r;
    endfunction

    // Compare current outputs with the model, then record what the next edge will do.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_t e;
        if (armed) begin
            exp_rdy = ena && ((q.size() < 2) || out_ready);
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (q.size() == 0) check("out_valid_idle", {31'b0, out_valid}, 32'd0);
            if (out_valid && q.size() > 0) begin
                e = q[0];
                check("data_out", {28'b0, data_out}, {28'b0, e.data});
                check("syndrome_out", {29'b0, syndrome_out}, {29'b0, e.syn});
                check("corrected", {31'b0, corrected}, {31'b0, e.corr});
            end
            check("err_count", 32'(err_count), 32'(cnt_m));
        end
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            armed = 1'b1;
        end else if (armed && ena) begin
            if (CNT_ON && cnt_clr) cnt_m = 0;
            if (out_valid && out_ready && q.size() > 0) begin
                if (CNT_ON && !cnt_clr && q[0].corr && cnt_m < CNT_MAX) cnt_m++;
                void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_decode(code_in));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] c);
        int guard;
        tick();
        code_in  = c;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        code_in  = 7'($urandom);
    endtask

    task automatic send_expect(input string name, input logic [6:0] c, input logic [3:0] d,
                               input logic [2:0] s, input logic corr);
        send(c);
        @(negedge clk);
        check({name, "_early"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_result"}, {24'b0, data_out, syndrome_out, corrected}, {24'b0, d, s, corr});
    endtask

    task automatic collect(input int n, output logic [11:0] res, output int got);
        res = '0;
        got = 0;
        for (int k = 0; k < 60 && got < n; k++) begin
            @(negedge clk);
            if (out_valid && out_ready && ena) begin
                res = {res[7:0], data_out};
                got++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t r;
        logic [11:0] res;
        int got;
        logic [3:0] dv;

        // Pin the model with hand-decoded words.
        r = ref_decode(7'h55); check("pin_55", {24'b0, r.data, r.syn, r.corr}, {24'b0, 4'hB, 3'd0, 1'b0});
        r = ref_decode(7'h45); check("pin_45", {24'b0, r.data, r.syn, r.corr}, {24'b0, 4'hB, 3'd3, 1'b1});
        r = ref_decode(7'h15); check("pin_15", {24'b0, r.data, r.syn, r.corr}, {24'b0, 4'hB, 3'd1, 1'b1});
        r = ref_decode(7'h7F); check("pin_7f", {24'b0, r.data, r.syn, r.corr}, {24'b0, 4'hF, 3'd0, 1'b0});

        // Reset
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out", {24'b0, out_valid, data_out, syndrome_out}, 32'd0);
        check("rst_corr_cnt", {29'b0, corrected, err_count}, 32'd0);

        // Clean, data-bit and parity-bit errors
        send_expect("clean_55", 7'h55, 4'hB, 3'd0, 1'b0);
        send_expect("data_err_45", 7'h45, 4'hB, 3'd3, 1'b1);
        @(negedge clk);
        check("cnt_after_45", 32'(err_count), CNT_ON ? 32'd1 : 32'd0);
        send_expect("par_err_15", 7'h15, 4'hB, 3'd1, 1'b1);
        send_expect("clean_7f", 7'h7F, 4'hF, 3'd0, 1'b0);

        // Backpressure
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 7'h00;
        @(negedge clk); check("bp_rdy0", {31'b0, in_ready}, 32'd1);
        tick();
        code_in = 7'h7F;
        @(negedge clk); check("bp_rdy1", {31'b0, in_ready}, 32'd1);
        tick();
        code_in = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
            check("bp_stall_out", {27'b0, out_valid, data_out}, {27'b0, 1'b1, 4'h0});
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        check("bp_first", {27'b0, out_valid, data_out}, {27'b0, 1'b1, 4'h0});
        tick();
        in_valid = 1'b0;
        collect(2, res, got);
        check("bp_order", {20'b0, res}, 32'h0FB);
        check("bp_count", 32'(got), 32'd2);

        // Enable freeze mid-stream
        tick();
        in_valid = 1'b1;
        code_in  = 7'h7F;
        tick();
        code_in = 7'h45;
        tick();
        ena     = 1'b0;
        code_in = 7'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ena_rdy", {31'b0, in_ready}, 32'd0);
            check("ena_hold", {27'b0, out_valid, data_out}, {27'b0, 1'b1, 4'hF});
            tick();
        end
        ena      = 1'b1;
        in_valid = 1'b0;
        collect(2, res, got);
        check("ena_order", {20'b0, res}, 32'h0FB);
        check("ena_count", 32'(got), 32'd2);

        // Reset with a word in flight
        tick();
        in_valid = 1'b1;
        code_in  = 7'h55;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_drop", {31'b0, out_valid}, 32'd0);
            tick();
        end

        // Counter saturation and clear-vs-increment priority
        for (int i = 0; i < 5; i++) begin
            dv = 4'($urandom);
            send(encode(dv) ^ (7'd1 << $urandom_range(6, 0)));
        end
        repeat (3) tick();
        @(negedge clk);
        check("cnt_sat", 32'(err_count), CNT_ON ? 32'(CNT_MAX) : 32'd0);
        send(7'h45);
        tick();
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_pre", {30'b0, out_valid, corrected}, 32'd3);
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_prio", 32'(err_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick();
            in_valid  = ($urandom_range(99, 0) < 60);
            code_in   = 7'($urandom);
            out_ready = ($urandom_range(99, 0) < 70);
            ena       = ($urandom_range(99, 0) < 90);
            cnt_clr   = ($urandom_range(99, 0) < 4);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ena       = 1'b1;
        cnt_clr   = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);
        check("drain_no_loss", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
